hilo_div_unit: RTL and testbench

HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

---
 rtl/hilo_div_unit_pkg.sv | 27 ++
 rtl/div_step.sv | 21 ++
 rtl/hilo_div_unit.sv | 152 +++++++++++++++
 tb/tb_hilo_div_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_unit_pkg.sv
// Shared encodings for the HI/LO + divide unit: op codes, FSM states, iteration count.
package hilo_div_unit_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpCapt = 3'd1,
    OpMthi = 3'd2,
    OpMtlo = 3'd3,
    OpDivu = 3'd4,
    OpDiv  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  localparam int unsigned DivIters = 32;
  localparam int unsigned CntW     = $clog2(DivIters);

  // True for op codes that do real work (NOP and 6..7 are dropped).
  function automatic logic op_legal(input logic [2:0] o);
    return (o >= 3'd1) && (o <= 3'd5);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and shift the resulting quotient bit in.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [32:0] trial;

  // Remainder stays below the divisor, so the shifted value fits 33 bits.
  assign shifted  = {rem, quo[31]};
  assign trial    = shifted - {1'b0, divisor};
  // A borrow (trial[32]) means the subtract failed: restore and shift in 0.
  assign rem_next = trial[32] ? shifted[31:0] : trial[31:0];
  assign quo_next = {quo[30:0], ~trial[32]};

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register file with multicycle restoring divider (DIVU/DIV), CAPT and MTHI/MTLO.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  op,
  input  logic        op_valid,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_r2,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       dvs_q, dvs_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              done_q, done_d;

  logic              accept;
  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [31:0]       step_rem;
  logic [31:0]       step_quo;

  // Ops are only taken in IDLE; anything offered while dividing is dropped.
  assign accept    = op_valid && (state_q == StIdle) && op_legal(op);
  assign is_signed = (op == OpDiv);
  assign a_neg     = is_signed & a[31];
  assign b_neg     = is_signed & b[31];

  div_step u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Next-state logic for the FSM, divider datapath and architectural HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpCapt: begin
              lo_d   = alu_r;
              hi_d   = alu_r2;
              done_d = 1'b1;
            end
            OpMthi: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OpMtlo: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            OpDivu, OpDiv: begin
              if (b == 32'd0) begin
                // Divide-by-zero completes immediately with a fixed result.
                hi_d   = a;
                lo_d   = '1;
                done_d = 1'b1;
              end else begin
                rem_d   = '0;
                quo_d   = a_neg ? -a : a;
                dvs_d   = b_neg ? -b : b;
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
                cnt_d   = CntW'(DivIters - 1);
                state_d = StRun;
              end
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        lo_d    = negq_q ? -quo_q : quo_q;
        hi_d    = negr_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers, so op_valid never reaches busy/done combinationally.
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed cases plus randomized ops vs. an arithmetic model.
module tb_hilo_div_unit;
  import hilo_div_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  op;
  logic        op_valid;
  logic [31:0] alu_r;
  logic [31:0] alu_r2;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_div_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .op_valid (op_valid),
    .alu_r    (alu_r),
    .alu_r2   (alu_r2),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Architectural result of one op, from plain integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ir, input logic [31:0] ir2,
                       output logic [31:0] eh, output logic [31:0] el);
    int sa;
    int sb;
    eh = m_hi;
    el = m_lo;
    case (o)
      3'd1: begin el = ir; eh = ir2; end
      3'd2: eh = ia;
      3'd3: el = ia;
      3'd4, 3'd5: begin
        if (ib == 32'd0) begin
          eh = ia;
          el = 32'hFFFF_FFFF;
        end else if (o == 3'd4) begin
          el = ia / ib;
          eh = ia % ib;
        end else if (ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else begin
          sa = ia;
          sb = ib;
          el = sa / sb;
          eh = sa % sb;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one op, follow it to completion and compare timing and HI/LO. inject>=0 offers an
  // MTHI at that many cycles after the first busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] ir, input logic [31:0] ir2,
                        input int inject);
    logic [31:0] eh;
    logic [31:0] el;
    int n;
    bit is_div;
    model(o, ia, ib, ir, ir2, eh, el);
    is_div   = (o == 3'd4 || o == 3'd5) && (ib != 32'd0);
    op       = o;
    op_valid = 1'b1;
    a        = ia;
    b        = ib;
    alu_r    = ir;
    alu_r2   = ir2;
    tick();
    op_valid = 1'b0;
    op       = OpNop;
    a        = $urandom;
    b        = $urandom;
    if (is_div) begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        if (n == 16) begin
          check32({tag, "_hold_hi"}, hi, m_hi);
          check32({tag, "_hold_lo"}, lo, m_lo);
          check32({tag, "_done_while_busy"}, {31'd0, done}, 32'd0);
        end
        if (n == inject) begin
          op       = OpMthi;
          a        = 32'h1234;
          op_valid = 1'b1;
        end else begin
          op_valid = 1'b0;
        end
        tick();
        n++;
      end
      op_valid = 1'b0;
      check_int({tag, "_busy_cycles"}, n, 33);
    end else begin
      check32({tag, "_busy"}, {31'd0, busy}, 32'd0);
    end
    check32({tag, "_done"}, {31'd0, done}, 32'd1);
    check32({tag, "_hi"}, hi, eh);
    check32({tag, "_lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  // Offer an op that must have no effect (reserved/NOP code, or op_valid low).
  task automatic run_ignored(input string tag, input logic [2:0] o, input logic v);
    op       = o;
    op_valid = v;
    a        = $urandom;
    alu_r    = $urandom;
    alu_r2   = $urandom;
    b        = $urandom_range(1, 9);
    tick();
    op_valid = 1'b0;
    check32({tag, "_done"}, {31'd0, done}, 32'd0);
    check32({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check32({tag, "_hi"}, hi, m_hi);
    check32({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rb;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    op       = OpNop;
    op_valid = 1'b0;
    alu_r    = '0;
    alu_r2   = '0;
    a        = '0;
    b        = '0;
    m_hi     = '0;
    m_lo     = '0;
    tick();
    tick();
    tick();
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;

    // CAPT, then done must drop after one cycle.
    run_op("capt", OpCapt, 32'd0, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, -1);
    tick();
    check32("capt_done_pulse", {31'd0, done}, 32'd0);

    run_op("divu_100_7", OpDivu, 32'd100, 32'd7, '0, '0, -1);
    // Back-to-back: next op offered in the same cycle done=1.
    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, '0, '0, -1);
    run_op("div_min_m1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, -1);
    run_op("divu_5_0", OpDivu, 32'd5, 32'd0, '0, '0, -1);
    run_op("mthi", OpMthi, 32'hCAFE_0001, '0, '0, '0, -1);
    run_op("mtlo", OpMtlo, 32'hBEEF_0002, '0, '0, '0, -1);
    run_op("divu_big", OpDivu, 32'hFFFF_FFFF, 32'h0000_0003, '0, '0, -1);
    run_op("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, '0, '0, -1);

    // MTHI offered at N+5 of a running divide must be ignored.
    run_op("divu_inject", OpDivu, 32'd1000, 32'd33, '0, '0, 4);

    run_ignored("rsv6", 3'd6, 1'b1);
    run_ignored("rsv7", 3'd7, 1'b1);
    run_ignored("nop", OpNop, 1'b1);
    run_ignored("novalid", OpCapt, 1'b0);

    // Reset at N+10 of a divide aborts it with HI/LO cleared; reset beats op_valid.
    op       = OpDivu;
    op_valid = 1'b1;
    a        = 32'd12345;
    b        = 32'd17;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset_n  = 1'b0;
    op       = OpCapt;
    op_valid = 1'b1;
    alu_r    = 32'h5555_5555;
    alu_r2   = 32'hAAAA_AAAA;
    tick();
    check32("midrst_hi", hi, 32'd0);
    check32("midrst_lo", lo, 32'd0);
    check32("midrst_busy", {31'd0, busy}, 32'd0);
    check32("midrst_done", {31'd0, done}, 32'd0);
    reset_n  = 1'b1;
    op_valid = 1'b0;
    m_hi     = '0;
    m_lo     = '0;
    run_op("divu_9_3", OpDivu, 32'd9, 32'd3, '0, '0, -1);

    // Randomized ops against the model.
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(1, 5));
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = -32'($urandom_range(1, 15));
      endcase
      run_op("rand", ro, $urandom, rb, $urandom, $urandom, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
